calc_sequencer: RTL and testbench

- Keypad-entry sequencer that drives the 4-bit calculator operator datapath. It collects operand A, an operator key and operand B from one-cycle key strobes.
- It generates the operator's phase code q, the operand/opcode buses and a one-cycle execute strobe e.
- Sits between the debounced keypad decoder and the operator; also owns display timeout and entry-error handling.

---
 rtl/calc_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_calc_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
// Keypad-entry sequencer for the 4-bit calculator operator: A, operator, B, equals -> one-cycle execute strobe.
// Every output is registered, so key effects appear one cycle after the strobe; there is no backpressure and unusable keys are dropped.
module calc_sequencer #(
    parameter int TIMEOUT_CYCLES = 50000000,
    parameter int CNT_W          = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [1:0] q,
    output logic [3:0] a_out,
    output logic [3:0] op_out,
    output logic [3:0] b_out,
    output logic       e,
    output logic       busy,
    output logic       err
);

    typedef enum logic [2:0] {
        S_CLR,
        S_A,
        S_OP,
        S_B,
        S_EXEC,
        S_SHOW,
        S_ERR
    } state_t;

    localparam logic [1:0] Q_ENTRY_A = 2'b00;
    localparam logic [1:0] Q_CLEAR   = 2'b01;
    localparam logic [1:0] Q_ENTRY_B = 2'b10;
    localparam logic [1:0] Q_RESULT  = 2'b11;

    localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    logic [1:0]       r_q;
    logic [3:0]       r_a;
    logic [3:0]       r_op;
    logic [3:0]       r_b;
    logic             r_b_valid;
    logic [CNT_W-1:0] r_timer;
    logic             r_e;
    logic             r_busy;
    logic             r_err;

    logic w_digit;
    logic w_oper;
    logic w_equ;
    logic w_clr;

    // Code 1111 matches none of these, so it is ignored everywhere.
    assign w_digit = key_valid && (key_code <= 4'd9);
    assign w_oper  = key_valid && (key_code >= 4'hA) && (key_code <= 4'hC);
    assign w_equ   = key_valid && (key_code == 4'hD);
    assign w_clr   = key_valid && (key_code == 4'hE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_CLR;
            r_q       <= Q_CLEAR;
            r_a       <= 4'd0;
            r_op      <= 4'd0;
            r_b       <= 4'd0;
            r_b_valid <= 1'b0;
            r_timer   <= '0;
            r_e       <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_e    <= 1'b0;
            r_busy <= 1'b0;
            // Every entry into S_CLR wipes the operand buses and the error flag,
            // so they already read zero during the single clear cycle.
            case (r_state)
                S_CLR: begin
                    r_state <= S_A;
                    r_q     <= Q_ENTRY_A;
                end

                S_A: begin
                    if (w_clr) begin
                        r_state   <= S_CLR;
                        r_q       <= Q_CLEAR;
                        r_a       <= 4'd0;
                        r_op      <= 4'd0;
                        r_b       <= 4'd0;
                        r_b_valid <= 1'b0;
                        r_err     <= 1'b0;
                    end else if (w_digit) begin
                        r_a     <= key_code;
                        r_state <= S_OP;
                    end else if (w_oper || w_equ) begin
                        r_state <= S_ERR;
                        r_q     <= Q_CLEAR;
                        r_err   <= 1'b1;
                    end
                end

                S_OP: begin
                    if (w_clr) begin
                        r_state   <= S_CLR;
                        r_q       <= Q_CLEAR;
                        r_a       <= 4'd0;
                        r_op      <= 4'd0;
                        r_b       <= 4'd0;
                        r_b_valid <= 1'b0;
                        r_err     <= 1'b0;
                    end else if (w_digit) begin
                        r_a <= key_code;
                    end else if (w_oper) begin
                        r_op    <= key_code;
                        r_state <= S_B;
                        r_q     <= Q_ENTRY_B;
                    end else if (w_equ) begin
                        r_state <= S_ERR;
                        r_q     <= Q_CLEAR;
                        r_err   <= 1'b1;
                    end
                end

                S_B: begin
                    if (w_clr) begin
                        r_state   <= S_CLR;
                        r_q       <= Q_CLEAR;
                        r_a       <= 4'd0;
                        r_op      <= 4'd0;
                        r_b       <= 4'd0;
                        r_b_valid <= 1'b0;
                        r_err     <= 1'b0;
                    end else if (w_digit) begin
                        r_b       <= key_code;
                        r_b_valid <= 1'b1;
                    end else if (w_oper && !r_b_valid) begin
                        r_op <= key_code;
                    end else if (w_equ && r_b_valid) begin
                        r_state <= S_EXEC;
                        r_e     <= 1'b1;
                        r_busy  <= 1'b1;
                    end else if (w_oper || w_equ) begin
                        r_state <= S_ERR;
                        r_q     <= Q_CLEAR;
                        r_err   <= 1'b1;
                    end
                end

                S_EXEC: begin
                    r_timer <= '0;
                    r_state <= S_SHOW;
                    r_q     <= Q_RESULT;
                end

                S_SHOW: begin
                    // A usable key beats the timeout; operator/equals fall through to it.
                    if (w_clr || (!w_digit && r_timer == TIMER_LAST)) begin
                        r_state   <= S_CLR;
                        r_q       <= Q_CLEAR;
                        r_a       <= 4'd0;
                        r_op      <= 4'd0;
                        r_b       <= 4'd0;
                        r_b_valid <= 1'b0;
                        r_err     <= 1'b0;
                    end else if (w_digit) begin
                        r_a       <= key_code;
                        r_op      <= 4'd0;
                        r_b       <= 4'd0;
                        r_b_valid <= 1'b0;
                        r_state   <= S_OP;
                        r_q       <= Q_ENTRY_A;
                    end else begin
                        r_timer <= r_timer + CNT_W'(1);
                    end
                end

                S_ERR: begin
                    if (w_clr) begin
                        r_state   <= S_CLR;
                        r_q       <= Q_CLEAR;
                        r_a       <= 4'd0;
                        r_op      <= 4'd0;
                        r_b       <= 4'd0;
                        r_b_valid <= 1'b0;
                        r_err     <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_CLR;
                    r_q     <= Q_CLEAR;
                end
            endcase
        end
    end

    assign q      = r_q;
    assign a_out  = r_a;
    assign op_out = r_op;
    assign b_out  = r_b;
    assign e      = r_e;
    assign busy   = r_busy;
    assign err    = r_err;

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer with a short timeout; execute strobes are checked against a queue of expected operands.
module tb_calc_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_valid;
    logic [3:0] key_code;
    logic [1:0] q;
    logic [3:0] a_out;
    logic [3:0] op_out;
    logic [3:0] b_out;
    logic       e;
    logic       busy;
    logic       err;

    int n_checks = 0;
    int n_errors = 0;
    int n_pulses = 0;
    logic [11:0] exp_q[$];

    calc_sequencer #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .key_valid(key_valid),
        .key_code (key_code),
        .q        (q),
        .a_out    (a_out),
        .op_out   (op_out),
        .b_out    (b_out),
        .e        (e),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Execute monitor: every e pulse must match the oldest expected {a, op, b}.
    always @(negedge clk) begin
        if (e === 1'b1 || busy === 1'b1) begin
            n_checks++;
            if (busy !== e) begin
                n_errors++;
                $display("FAIL busy_eq_e busy=%b e=%b", busy, e);
            end
        end
        if (e === 1'b1) begin
            n_pulses++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL exec_unexpected got a/op/b=%h expected no pulse", {a_out, op_out, b_out});
            end else begin
                logic [11:0] exp_v;
                exp_v = exp_q.pop_front();
                if ({a_out, op_out, b_out} !== exp_v) begin
                    n_errors++;
                    $display("FAIL exec_operands got=%h exp=%h", {a_out, op_out, b_out}, exp_v);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] c);
        key_valid = 1'b1;
        key_code  = c;
        tick();
        key_valid = 1'b0;
        key_code  = 4'hF;
    endtask

    task automatic show_len(output int n);
        n = 0;
        while (q === 2'b11 && n < 20) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        key_valid = 1'b1;
        key_code = 4'd5;
        tick();
        tick();
        n_checks++; if (q !== 2'b01) begin n_errors++; $display("FAIL rst_q got=%b exp=01", q); end
        n_checks++; if ({a_out, op_out, b_out} !== 12'h000) begin n_errors++; $display("FAIL rst_bus got=%h exp=000", {a_out, op_out, b_out}); end
        n_checks++; if ({e, busy, err} !== 3'b000) begin n_errors++; $display("FAIL rst_flags got=%b exp=000", {e, busy, err}); end
        reset = 1'b1;
        key_valid = 1'b0;
        key_code = 4'hF;
        tick();
        n_checks++; if (q !== 2'b00) begin n_errors++; $display("FAIL rst_release_q got=%b exp=00", q); end
    endtask

    task automatic test_basic();
        key(4'd3);
        n_checks++; if (q !== 2'b00 || a_out !== 4'd3) begin n_errors++; $display("FAIL basic_a got q=%b a=%h exp q=00 a=3", q, a_out); end
        tick();
        key(4'hA);
        n_checks++; if (q !== 2'b10 || op_out !== 4'hA) begin n_errors++; $display("FAIL basic_op got q=%b op=%h exp q=10 op=a", q, op_out); end
        tick();
        key(4'd4);
        n_checks++; if (q !== 2'b10 || b_out !== 4'd4) begin n_errors++; $display("FAIL basic_b got q=%b b=%h exp q=10 b=4", q, b_out); end
        tick();
        exp_q.push_back({4'd3, 4'hA, 4'd4});
        key(4'hD);
        n_checks++; if ({q, e, busy, err} !== 5'b10110) begin n_errors++; $display("FAIL basic_exec got q/e/busy/err=%b exp=10110", {q, e, busy, err}); end
        tick();
        n_checks++; if ({q, e, busy} !== 4'b1100) begin n_errors++; $display("FAIL basic_show got q/e/busy=%b exp=1100", {q, e, busy}); end
    endtask

    task automatic test_timeout();
        int n;
        key(4'hE);
        n_checks++; if (q !== 2'b01) begin n_errors++; $display("FAIL to_clear_q got=%b exp=01", q); end
        tick();
        key(4'd9); tick();
        key(4'hB); tick();
        key(4'd2); tick();
        exp_q.push_back({4'd9, 4'hB, 4'd2});
        key(4'hD);
        tick();
        show_len(n);
        n_checks++; if (n != 8) begin n_errors++; $display("FAIL to_show_len got=%0d exp=8", n); end
        n_checks++; if (q !== 2'b01) begin n_errors++; $display("FAIL to_clr_q got=%b exp=01", q); end
        tick();
        n_checks++; if (q !== 2'b00 || {a_out, op_out, b_out} !== 12'h000) begin n_errors++; $display("FAIL to_idle got q=%b bus=%h exp q=00 bus=000", q, {a_out, op_out, b_out}); end
    endtask

    task automatic test_error();
        key(4'hC);
        n_checks++; if ({q, err} !== 3'b011) begin n_errors++; $display("FAIL err_op_in_a got q/err=%b exp=011", {q, err}); end
        key(4'hE);
        tick();
        key(4'd5);
        key(4'hF);
        n_checks++; if (q !== 2'b00 || a_out !== 4'd5) begin n_errors++; $display("FAIL err_noop got q=%b a=%h exp q=00 a=5", q, a_out); end
        key(4'hD);
        n_checks++; if ({q, err} !== 3'b011) begin n_errors++; $display("FAIL err_equ_in_op got q/err=%b exp=011", {q, err}); end
        key(4'd7);
        key(4'hD);
        key(4'hA);
        n_checks++; if ({q, err} !== 3'b011 || a_out !== 4'd5) begin n_errors++; $display("FAIL err_sticky got q/err=%b a=%h exp 011 a=5", {q, err}, a_out); end
        key(4'hE);
        n_checks++; if ({q, err} !== 3'b010) begin n_errors++; $display("FAIL err_clear got q/err=%b exp=010", {q, err}); end
        tick();
        n_checks++; if (q !== 2'b00) begin n_errors++; $display("FAIL err_resume got q=%b exp=00", q); end
    endtask

    task automatic test_last_wins();
        key(4'd7); key(4'd2); key(4'hC); key(4'hB); key(4'd6);
        n_checks++; if ({a_out, op_out, b_out} !== 12'h2B6) begin n_errors++; $display("FAIL lw_bus got=%h exp=2b6", {a_out, op_out, b_out}); end
        exp_q.push_back({4'd2, 4'hB, 4'd6});
        key(4'hD);
        n_checks++; if (e !== 1'b1) begin n_errors++; $display("FAIL lw_exec got e=%b exp=1", e); end
        tick();
        key(4'hE);
        tick();
        key(4'd1); key(4'hC); key(4'd3); key(4'hA);
        n_checks++; if ({q, err} !== 3'b011 || op_out !== 4'hC) begin n_errors++; $display("FAIL lw_op_after_b got q/err=%b op=%h exp 011 op=c", {q, err}, op_out); end
        key(4'hE);
        tick();
    endtask

    task automatic test_reset_mid();
        key(4'd1); key(4'hC); key(4'd5);
        n_checks++; if (q !== 2'b10 || b_out !== 4'd5) begin n_errors++; $display("FAIL rm_setup got q=%b b=%h exp q=10 b=5", q, b_out); end
        reset = 1'b0;
        key_valid = 1'b1;
        key_code = 4'd8;
        tick();
        n_checks++; if ({q, e, err} !== 4'b0100 || {a_out, op_out, b_out} !== 12'h000) begin n_errors++; $display("FAIL rm_reset got q/e/err=%b bus=%h exp 0100 bus=000", {q, e, err}, {a_out, op_out, b_out}); end
        reset = 1'b1;
        key_valid = 1'b0;
        key_code = 4'hF;
        tick();
        n_checks++; if (q !== 2'b00) begin n_errors++; $display("FAIL rm_release got q=%b exp=00", q); end
    endtask

    task automatic test_exec_drop();
        int n;
        key(4'd2); key(4'hC); key(4'd3);
        exp_q.push_back({4'd2, 4'hC, 4'd3});
        key_valid = 1'b1;
        key_code = 4'hD;
        tick();
        key_code = 4'd9;
        tick();
        key_valid = 1'b0;
        key_code = 4'hF;
        n_checks++; if (q !== 2'b11 || b_out !== 4'd3 || e !== 1'b0) begin n_errors++; $display("FAIL ed_drop got q=%b b=%h e=%b exp q=11 b=3 e=0", q, b_out, e); end
        tick(); tick(); tick();
        key(4'd4);
        n_checks++; if (q !== 2'b00 || {a_out, op_out, b_out} !== 12'h400) begin n_errors++; $display("FAIL ed_new_calc got q=%b bus=%h exp q=00 bus=400", q, {a_out, op_out, b_out}); end
        key(4'hB); key(4'd1);
        exp_q.push_back({4'd4, 4'hB, 4'd1});
        key(4'hD);
        tick();
        show_len(n);
        n_checks++; if (n != 8) begin n_errors++; $display("FAIL ed_timer_reload got=%0d exp=8", n); end
        n_checks++; if (q !== 2'b01) begin n_errors++; $display("FAIL ed_timeout_q got=%b exp=01", q); end
        tick();
    endtask

    initial begin
        reset = 1'b0;
        key_valid = 1'b0;
        key_code = 4'hF;
        test_reset();
        test_basic();
        test_timeout();
        test_error();
        test_last_wins();
        test_reset_mid();
        test_exec_drop();
        tick(); tick();
        n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); end
        n_checks++; if (n_pulses != 5) begin n_errors++; $display("FAIL pulse_count got=%0d exp=5", n_pulses); end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
